timer_counter_array: RTL and testbench
======================================

// Module: timer_counter_array
// PURPOSE
//  Parametrised N-channel timer/counter array; successor of the two-channel timer_counter.
//  Every channel counts up or down between a load value and a compare value.
//  It supports auto-reload, a shared clock prescaler and cascading from channel k-1's done pulse.
//  Sits behind the AXI4-Lite register file; done/irq outputs feed the interrupt controller.
// PARAMETERS
//  NUM_CH      4   number of channels (>=1)
//  CNT_W       32  counter/load/compare width per channel
//  PRESCALE_W  8   prescaler divide-value width
// PORTS
//  clk              in   1               system clock, all logic on rising edge
//  rst_n            in   1               asynchronous active-low reset
//  i_prescale       in   PRESCALE_W      tick every i_prescale+1 clk cycles
//  i_en             in   NUM_CH          per-channel enable
//  i_reload         in   NUM_CH          1: reload on match; 0: free-run past compare
//  i_count_up       in   NUM_CH          1: increment; 0: decrement
//  i_src            in   NUM_CH          0: prescaler tick; 1: o_done[k-1] (ignored for ch0)
//  i_load_value     in   NUM_CH*CNT_W    ch k at [k*CNT_W +: CNT_W]
//  i_compare_value  in   NUM_CH*CNT_W    same packing
//  i_irq_clr        in   NUM_CH          per-channel sticky-irq clear (see CONFIGURATION)
//  o_done           out  NUM_CH          one-cycle match pulse, registered
//  o_irq            out  NUM_CH          interrupt (see CONFIGURATION)
//  o_value          out  NUM_CH*CNT_W    current counter values, registered
// BEHAVIOUR
//  Reset: o_value=0, o_done=0, o_irq=0, prescaler count=0.
//  Prescaler: free-running down-counter, shared; tick=1 for one cycle when count==0, then reload
//   i_prescale; i_prescale=0 -> tick every cycle. New i_prescale takes effect at next reload.
//  step[k] = i_en[k] & (i_src[k] && k>0 ? o_done[k-1] : tick).
//  i_en[k]=0: value<=load, done<=0 every cycle (disable mid-count aborts, 1-cycle latency).
//  i_en[k]=1, step: if value==compare && i_reload -> next=load;
//   else next=value+1 (up) / value-1 (down), modulo 2^CNT_W (FFFF..F->0, 0->FFFF..F).
//  done[k] <= step[k] && (next==compare): pulse coincides with o_value==compare.
//  No step: value and done(=0) held/cleared; done never wider than 1 cycle per step.
//  Period with reload and prescale 0: |compare-load|+1 cycles; load==compare -> done every step.
//  Compare/load/direction sampled live each cycle; changes apply to the next step.
//  Cascade: ch k steps the cycle o_done[k-1]=1 (1 cycle latency per stage); chains freely.
//  i_reload=0: after match counter continues and wraps; done repeats after 2^CNT_W steps.
// CONFIGURATION
//  Macro TIMER_STICKY_IRQ_EN:
//   defined: o_irq[k] is sticky, set by o_done[k], cleared by i_irq_clr[k]; set wins if coincident;
//    i_en[k]=0 does not clear o_irq[k].
//   undefined: o_irq = o_done (plain pulse); i_irq_clr ignored; no status flops.
// TESTING
//  1 ch0 up, load0 cmp100, reload, prescale0, en -> o_done[0] every 101 cycles, 1 cycle wide, value==100.
//  2 then i_en[0]=0 -> o_value ch0 == load (0) 1 cycle later and held, o_done[0]=0.
//  3 ch0 down, load100 cmp0, reload=0 -> done after 100 steps; value wraps to FFFF_FFFF, 5 cycles later > 2**30.
//  4 ch0 as 1, ch1 src=1 load0 cmp5 reload -> ch1 value +1 per ch0 done; o_done[1] with 5th ch0 done; next ch1=0.
//  5 prescale=3, ch2 up load0 cmp9 reload -> o_done[2] period exactly 40 cycles.
//  6 TIMER_STICKY_IRQ_EN: ch0 done -> o_irq[0]=1 held; i_irq_clr pulse -> 0; clr on done cycle -> stays 1.
//  7 assert rst_n low mid-count -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/timer_counter_array.sv
// N-channel up/down timer array with shared prescaler, auto-reload and cascading.
// Define TIMER_STICKY_IRQ_EN to make o_irq sticky (cleared by i_irq_clr).
module timer_counter_array #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PRESCALE_W-1:0]   i_prescale,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH-1:0]       i_reload,
  input  logic [NUM_CH-1:0]       i_count_up,
  input  logic [NUM_CH-1:0]       i_src,
  input  logic [NUM_CH*CNT_W-1:0] i_load_value,
  input  logic [NUM_CH*CNT_W-1:0] i_compare_value,
  input  logic [NUM_CH-1:0]       i_irq_clr,
  output logic [NUM_CH-1:0]       o_done,
  output logic [NUM_CH-1:0]       o_irq,
  output logic [NUM_CH*CNT_W-1:0] o_value
);

  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_d;
  logic                  tick;

  assign tick  = (pre_q == '0);
  assign pre_d = tick ? i_prescale : pre_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] done_d;
  logic [NUM_CH:0]   prev_done;

  // Channel k sees channel k-1's done at index k; ch0 sees constant 0.
  assign prev_done = {done_q, 1'b0};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] val_q;
    logic [CNT_W-1:0] val_d;
    logic [CNT_W-1:0] nxt;
    logic [CNT_W-1:0] ld;
    logic [CNT_W-1:0] cmp;
    logic             step;
    logic             cas;

    assign ld   = i_load_value[k*CNT_W +: CNT_W];
    assign cmp  = i_compare_value[k*CNT_W +: CNT_W];
    assign cas  = (k != 0) && i_src[k];
    assign step = i_en[k] & (cas ? prev_done[k] : tick);

    always_comb begin
      nxt = val_q;
      if (i_reload[k] && (val_q == cmp)) nxt = ld;
      else if (i_count_up[k])            nxt = val_q + CNT_W'(1);
      else                               nxt = val_q - CNT_W'(1);
    end

    always_comb begin
      val_d     = val_q;
      done_d[k] = 1'b0;
      if (!i_en[k]) begin
        val_d = ld;
      end else if (step) begin
        val_d     = nxt;
        done_d[k] = (nxt == cmp);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else        val_q <= val_d;
    end

    assign o_value[k*CNT_W +: CNT_W] = val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= '0;
    else        done_q <= done_d;
  end

  assign o_done = done_q;

`ifdef TIMER_STICKY_IRQ_EN
  logic [NUM_CH-1:0] irq_q;
  logic [NUM_CH-1:0] irq_d;

  // Set from the registered pulse so a clear on the done cycle loses.
  assign irq_d = done_q | (irq_q & ~i_irq_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_d;
  end

  assign o_irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^i_irq_clr;
  assign o_irq = done_q;
`endif

endmodule

// File: tb/tb_timer_counter_array.sv
// Self-checking bench for timer_counter_array (vector table + scoreboard
// queue, plus hand sequences for period, cascade, prescale, irq and reset).
module tb_timer_counter_array;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PW  = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PW-1:0]      prescale;
  logic [NCH-1:0]     en, rel, up, src, clr;
  logic [NCH*CW-1:0]  load_v, cmp_v;
  logic [NCH-1:0]     done, irq;
  logic [NCH*CW-1:0]  value;

  timer_counter_array #(
    .NUM_CH(NCH), .CNT_W(CW), .PRESCALE_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_prescale(prescale),
    .i_en(en), .i_reload(rel), .i_count_up(up), .i_src(src),
    .i_load_value(load_v), .i_compare_value(cmp_v),
    .i_irq_clr(clr), .o_done(done), .o_irq(irq), .o_value(value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [CW-1:0] load;
    logic [CW-1:0] cmp;
    logic          up;
    logic          rel;
    int            n;
    logic [CW-1:0] ev;
    logic          ed;
  } vec_t;

  typedef struct {
    logic [CW-1:0] v;
    logic          d;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] val(input int k);
    return value[k*CW +: CW];
  endfunction

  task automatic cfg(input int k, input logic [CW-1:0] ld,
                     input logic [CW-1:0] cp, input logic u,
                     input logic r, input logic s);
    load_v[k*CW +: CW] = ld;
    cmp_v[k*CW +: CW]  = cp;
    up[k]  = u;
    rel[k] = r;
    src[k] = s;
  endtask

  task automatic wait_done(input int k, input int bound, output int cyc);
    cyc = 0;
    do begin
      tk();
      cyc++;
    end while (!done[k] && cyc < bound);
    if (!done[k]) begin
      checks++;
      failures++;
      $display("FAIL timeout ch%0d: got no done expected done within %0d",
               k, bound);
    end
  endtask

  vec_t vecs[10];
  int   c, c2;
  exp_t e;

  initial begin
    vecs[0] = '{32'd0,   32'd100, 1'b1, 1'b1, 100, 32'd100, 1'b1};
    vecs[1] = '{32'd0,   32'd100, 1'b1, 1'b1, 101, 32'd0,   1'b0};
    vecs[2] = '{32'd100, 32'd0,   1'b0, 1'b0, 100, 32'd0,   1'b1};
    vecs[3] = '{32'd100, 32'd0,   1'b0, 1'b0, 101, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'hFFFF_FFFE, 32'd5, 1'b1, 1'b0, 3, 32'd1, 1'b0};
    vecs[5] = '{32'd7,   32'd7,   1'b1, 1'b1, 1,   32'd7,   1'b1};
    vecs[6] = '{32'd7,   32'd7,   1'b1, 1'b1, 4,   32'd7,   1'b1};
    vecs[7] = '{32'd10,  32'd3,   1'b0, 1'b1, 7,   32'd3,   1'b1};
    vecs[8] = '{32'd10,  32'd3,   1'b0, 1'b1, 8,   32'd10,  1'b0};
    vecs[9] = '{32'd0,   32'd100, 1'b1, 1'b1, 50,  32'd50,  1'b0};

    rst_n = 1'b0;
    prescale = '0;
    en = '0; rel = '0; up = '0; src = '0; clr = '0;
    load_v = '0; cmp_v = '0;
    #12;
    chk("reset_value", {32'd0, value[63:32] | value[31:0] | value[127:96]
                        | value[95:64]}, 64'd0);
    chk("reset_done", {60'd0, done}, 64'd0);
    chk("reset_irq", {60'd0, irq}, 64'd0);
    rst_n = 1'b1;
    tk();

    // Table: ch0 only, prescale 0 (step every cycle).
    for (int i = 0; i < 10; i++) begin
      en[0] = 1'b0;
      cfg(0, vecs[i].load, vecs[i].cmp, vecs[i].up, vecs[i].rel, 1'b0);
      tk();
      en[0] = 1'b1;
      sb.push_back('{vecs[i].ev, vecs[i].ed});
      repeat (vecs[i].n) tk();
      e = sb.pop_front();
      chk($sformatf("vec%0d_value", i), {32'd0, val(0)}, {32'd0, e.v});
      chk($sformatf("vec%0d_done", i), {63'd0, done[0]}, {63'd0, e.d});
    end

    // Period 101, pulse width 1, value at compare.
    en[0] = 1'b0;
    cfg(0, 32'd0, 32'd100, 1'b1, 1'b1, 1'b0);
    tk();
    en[0] = 1'b1;
    wait_done(0, 300, c);
    chk("t1_first_steps", c, 100);
    chk("t1_value_at_done", {32'd0, val(0)}, 64'd100);
    tk();
    chk("t1_width", {63'd0, done[0]}, 64'd0);
    wait_done(0, 300, c2);
    chk("t1_period", c2 + 1, 101);

    // Disable aborts the count.
    en[0] = 1'b0;
    tk();
    chk("t2_value_load", {32'd0, val(0)}, 64'd0);
    chk("t2_done", {63'd0, done[0]}, 64'd0);
    repeat (3) tk();
    chk("t2_value_held", {32'd0, val(0)}, 64'd0);

`ifdef TIMER_STICKY_IRQ_EN
    clr[0] = 1'b1;
    tk();
    clr[0] = 1'b0;
    en[0] = 1'b1;
    wait_done(0, 300, c);
    tk();
    chk("t6_irq_set", {63'd0, irq[0]}, 64'd1);
    repeat (3) tk();
    chk("t6_irq_held", {63'd0, irq[0]}, 64'd1);
    clr[0] = 1'b1;
    tk();
    clr[0] = 1'b0;
    chk("t6_irq_clr", {63'd0, irq[0]}, 64'd0);
    wait_done(0, 300, c);
    clr[0] = 1'b1;
    tk();
    clr[0] = 1'b0;
    chk("t6_set_wins", {63'd0, irq[0]}, 64'd1);
`else
    en[0] = 1'b1;
    wait_done(0, 300, c);
    chk("t6_irq_pulse", {63'd0, irq[0]}, 64'd1);
    clr[0] = 1'b1;
    tk();
    clr[0] = 1'b0;
    chk("t6_irq_low", {63'd0, irq[0]}, 64'd0);
`endif
    en[0] = 1'b0;
    tk();

    // Down count, no reload, wrap past zero.
    cfg(0, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
    tk();
    en[0] = 1'b1;
    wait_done(0, 300, c);
    chk("t3_steps", c, 100);
    chk("t3_value_zero", {32'd0, val(0)}, 64'd0);
    repeat (5) tk();
    chk("t3_wrap", {32'd0, val(0)}, {32'd0, 32'hFFFF_FFFB});
    chk("t3_big", {63'd0, val(0) > 32'h4000_0000}, 64'd1);
    en[0] = 1'b0;
    tk();

    // Cascade: ch1 steps once per ch0 done.
    cfg(0, 32'd0, 32'd100, 1'b1, 1'b1, 1'b0);
    cfg(1, 32'd0, 32'd5, 1'b1, 1'b1, 1'b1);
    tk();
    en[1:0] = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      wait_done(0, 300, c);
      tk();
      chk($sformatf("t4_ch1_value%0d", k), {32'd0, val(1)},
          64'(k % 6));
      chk($sformatf("t4_ch1_done%0d", k), {63'd0, done[1]},
          64'(k == 5));
    end
    en[1:0] = 2'b00;
    tk();

    // Prescale 3: ch2 period 4*10 cycles.
    prescale = 8'd3;
    cfg(2, 32'd0, 32'd9, 1'b1, 1'b1, 1'b0);
    tk();
    en[2] = 1'b1;
    wait_done(2, 200, c);
    wait_done(2, 200, c2);
    chk("t5_period", c2, 40);
    repeat (7) tk();

    // Async reset mid-count.
    #2 rst_n = 1'b0;
    #1;
    chk("t7_value", {32'd0, val(0) | val(1) | val(2) | val(3)}, 64'd0);
    chk("t7_done", {60'd0, done}, 64'd0);
    chk("t7_irq", {60'd0, irq}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
